// File: rtl/carry_look_ahead_adder.sv
// Registered WIDTH-bit adder: 4-bit carry-lookahead groups joined by a
// second-level lookahead unit, result captured one clock after in_valid.

module cla_group4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       grp_g,
    output logic       grp_p
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g = a & b;
        p = a ^ b;

        // Fully expanded carries so every carry is a two-level sum of products.
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);

        sum   = p ^ c;
        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
        grp_p = &p;
    end
endmodule

module cla_lookahead #(
    parameter int NG = 1
) (
    input  logic [NG-1:0] grp_g,
    input  logic [NG-1:0] grp_p,
    input  logic          cin,
    output logic [NG:0]   grp_c
);
    logic acc;
    logic prod;

    // Carry into group k is the OR over every source (cin or some G[j]) of
    // that source ANDed with all propagates above it, i.e. the expanded form.
    always_comb begin
        acc      = 1'b0;
        prod     = 1'b0;
        grp_c    = '0;
        grp_c[0] = cin;
        for (int k = 1; k <= NG; k++) begin
            acc = 1'b0;
            for (int j = -1; j < k; j++) begin
                if (j < 0) begin
                    prod = cin;
                end else begin
                    prod = grp_g[j];
                end
                for (int m = j + 1; m < k; m++) begin
                    prod = prod & grp_p[m];
                end
                acc = acc | prod;
            end
            grp_c[k] = acc;
        end
    end
endmodule

module carry_look_ahead_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             out_valid
);
    localparam int NG = WIDTH / 4;

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("carry_look_ahead_adder: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG:0]      grp_c;
    logic [WIDTH-1:0] raw_sum;

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_group
            cla_group4 u_group (
                .a     (a[gi*4 +: 4]),
                .b     (b[gi*4 +: 4]),
                .cin   (grp_c[gi]),
                .sum   (raw_sum[gi*4 +: 4]),
                .grp_g (grp_g[gi]),
                .grp_p (grp_p[gi])
            );
        end
    endgenerate

    cla_lookahead #(
        .NG (NG)
    ) u_lookahead (
        .grp_g (grp_g),
        .grp_p (grp_p),
        .cin   (cin),
        .grp_c (grp_c)
    );

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             carry_d;
    logic             carry_q;
    logic             out_valid_d;
    logic             out_valid_q;

    // Idle cycles keep the last result visible but drop out_valid.
    always_comb begin
        sum_d       = sum_q;
        carry_d     = carry_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            sum_d       = raw_sum;
            carry_d     = grp_c[NG];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_carry_look_ahead_adder.sv
// Directed bench for the registered CLA adder at WIDTH=4 and WIDTH=16,
// plus a randomised WIDTH=16 pass against a plain a+b+cin reference.

module tb_carry_look_ahead_adder;
    logic        clk;
    logic        rst;

    logic        in_valid4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        cin4;
    logic [3:0]  sum4;
    logic        carry4;
    logic        out_valid4;

    logic        in_valid16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        cin16;
    logic [15:0] sum16;
    logic        carry16;
    logic        out_valid16;

    int n_cmp;
    int n_mis;

    carry_look_ahead_adder #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .sum       (sum4),
        .carry     (carry4),
        .out_valid (out_valid4)
    );

    carry_look_ahead_adder #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid16),
        .a         (a16),
        .b         (b16),
        .cin       (cin16),
        .sum       (sum16),
        .carry     (carry16),
        .out_valid (out_valid16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs on the falling edge, let the rising edge capture, sample 1ns later.
    task automatic step4(input logic v, input logic [3:0] a_i, input logic [3:0] b_i, input logic c_i);
        @(negedge clk);
        in_valid4 = v;
        a4        = a_i;
        b4        = b_i;
        cin4      = c_i;
        @(posedge clk);
        #1;
    endtask

    task automatic step16(input logic v, input logic [15:0] a_i, input logic [15:0] b_i, input logic c_i);
        @(negedge clk);
        in_valid16 = v;
        a16        = a_i;
        b16        = b_i;
        cin16      = c_i;
        @(posedge clk);
        #1;
    endtask

    task automatic vec4(input string tag, input logic [3:0] a_i, input logic [3:0] b_i,
                        input logic c_i, input logic [3:0] exp_s, input logic exp_c);
        step4(1'b1, a_i, b_i, c_i);
        $display("txn %s: %b+%b cin%0d -> sum %b carry %0d valid %0d",
                 tag, a_i, b_i, c_i, sum4, carry4, out_valid4);
        check_eq({tag, ".sum"}, 32'(sum4), 32'(exp_s));
        check_eq({tag, ".carry"}, 32'(carry4), 32'(exp_c));
        check_eq({tag, ".valid"}, 32'(out_valid4), 32'd1);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] ref_sum;

        n_cmp      = 0;
        n_mis      = 0;
        rst        = 1'b1;
        in_valid4  = 1'b0;
        a4         = '0;
        b4         = '0;
        cin4       = 1'b0;
        in_valid16 = 1'b0;
        a16        = '0;
        b16        = '0;
        cin16      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.sum4", 32'(sum4), 32'd0);
        check_eq("rst.carry4", 32'(carry4), 32'd0);
        check_eq("rst.valid4", 32'(out_valid4), 32'd0);
        check_eq("rst.sum16", 32'(sum16), 32'd0);
        check_eq("rst.valid16", 32'(out_valid16), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step4(1'b0, 4'h0, 4'h0, 1'b0);
            $display("txn idle%0d: sum %b carry %0d valid %0d", i, sum4, carry4, out_valid4);
            check_eq("idle.sum", 32'(sum4), 32'd0);
            check_eq("idle.carry", 32'(carry4), 32'd0);
            check_eq("idle.valid", 32'(out_valid4), 32'd0);
        end

        vec4("v0", 4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b0);
        vec4("v1", 4'b1000, 4'b0101, 1'b1, 4'b1110, 1'b0);
        vec4("v2", 4'b0010, 4'b1001, 1'b0, 4'b1011, 1'b0);
        vec4("v3", 4'b1110, 4'b1001, 1'b1, 4'b1000, 1'b1);
        vec4("v4", 4'b0011, 4'b1101, 1'b0, 4'b0000, 1'b1);
        vec4("v5", 4'b1111, 4'b1001, 1'b1, 4'b1001, 1'b1);
        vec4("prop0", 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1);
        vec4("prop1", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);

        vec4("hold.load", 4'b0010, 4'b1001, 1'b0, 4'b1011, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step4(1'b0, 4'(4'hF - i), 4'(4'h3 + i), 1'(i));
            $display("txn hold%0d: sum %b carry %0d valid %0d", i, sum4, carry4, out_valid4);
            check_eq("hold.sum", 32'(sum4), 32'b1011);
            check_eq("hold.carry", 32'(carry4), 32'd0);
            check_eq("hold.valid", 32'(out_valid4), 32'd0);
        end

        @(negedge clk);
        rst = 1'b1;
        step4(1'b1, 4'b1111, 4'b1111, 1'b1);
        $display("txn rstprio: sum %b carry %0d valid %0d", sum4, carry4, out_valid4);
        check_eq("rstprio.sum", 32'(sum4), 32'd0);
        check_eq("rstprio.carry", 32'(carry4), 32'd0);
        check_eq("rstprio.valid", 32'(out_valid4), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        in_valid4 = 1'b0;
        @(posedge clk);
        #1;
        check_eq("postrst.valid", 32'(out_valid4), 32'd0);
        check_eq("postrst.sum", 32'(sum4), 32'd0);

        step16(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        $display("txn w16.cross: FFFF+0001 cin0 -> sum %h carry %0d", sum16, carry16);
        check_eq("w16.cross.sum", 32'(sum16), 32'h0000);
        check_eq("w16.cross.carry", 32'(carry16), 32'd1);
        check_eq("w16.cross.valid", 32'(out_valid16), 32'd1);

        step16(1'b1, 16'h0FFF, 16'h0000, 1'b1);
        $display("txn w16.grp: 0FFF+0000 cin1 -> sum %h carry %0d", sum16, carry16);
        check_eq("w16.grp.sum", 32'(sum16), 32'h1000);
        check_eq("w16.grp.carry", 32'(carry16), 32'd0);

        for (int i = 0; i < 200; i++) begin
            ra      = 16'($urandom);
            rb      = 16'($urandom);
            rc      = 1'($urandom);
            ref_sum = 17'(ra) + 17'(rb) + 17'(rc);
            step16(1'b1, ra, rb, rc);
            $display("txn w16.rnd%0d: %h+%h cin%0d -> %0d:%h", i, ra, rb, rc, carry16, sum16);
            check_eq("w16.rnd", 32'({carry16, sum16}), 32'(ref_sum));
        end
        step16(1'b0, 16'h1234, 16'h4321, 1'b1);
        check_eq("w16.idle.valid", 32'(out_valid16), 32'd0);
        check_eq("w16.idle.hold", 32'({carry16, sum16}), 32'(ref_sum));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
